// File: rtl/latch_debouncer_if.sv
// latch_debouncer_if
//   Groups the level/strobe signals between the latch and the debouncer.
//   master : drives din/en, observes dout/rise/fall/busy (latch side / bench)
//   slave  : the debouncer itself
//   din  - raw latch output level (asynchronous to clk, may bounce)
//   en   - sampling enable (mirror of the latch enable)
//   dout - debounced registered level
//   rise - one-cycle strobe on dout 0->1
//   fall - one-cycle strobe on dout 1->0
//   busy - a candidate level change is being counted
interface latch_debouncer_if;
  logic din;
  logic en;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, en, input dout, rise, fall, busy);
  modport slave  (input din, en, output dout, rise, fall, busy);
endinterface

// File: rtl/latch_debouncer.sv
// latch_debouncer
//   Brings the transparent latch output into the clk domain through a
//   SYNC_STAGES flop synchroniser, then accepts a new level only after
//   DEBOUNCE_CYCLES consecutive synchronised samples differ from the current
//   dout. Dropping en while counting aborts the candidate change.
// Parameters
//   SYNC_STAGES     2..4      synchroniser depth
//   DEBOUNCE_CYCLES 2..65535  matching samples needed to accept a new level
//   CNT_W           derived   counter width
// Ports
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - latch_debouncer_if.slave (din/en in; dout/rise/fall/busy out,
//           all outputs registered)
module latch_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  latch_debouncer_if.slave    bus
);

  typedef enum logic {STABLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync;

  state_t                 state_q, state_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic                   dout_q, dout_nxt;
  logic                   rise_q, rise_nxt;
  logic                   fall_q, fall_nxt;
  logic                   busy_q;

  // Synchroniser runs independently of en so that, when en returns, the
  // comparison is against a fresh sample rather than a stale one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.din};
  end

  assign sync = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      dout_q  <= dout_nxt;
      rise_q  <= rise_nxt;
      fall_q  <= fall_nxt;
      busy_q  <= (state_nxt == COUNT);
    end
  end

  // Counter holds the number of mismatching samples seen so far; the sample
  // that would make it DEBOUNCE_CYCLES commits instead, so it never reaches
  // that value and cannot wrap.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = '0;
    dout_nxt  = dout_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (bus.en && (sync != dout_q)) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      COUNT: begin
        // Abort is checked first so an en drop on the completing sample
        // suppresses the update.
        if (!bus.en) begin
          state_nxt = STABLE;
        end else if (sync == dout_q) begin
          state_nxt = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = STABLE;
          dout_nxt  = sync;
          rise_nxt  = sync;
          fall_nxt  = ~sync;
        end else begin
          cnt_nxt   = cnt_q + CNT_W'(1);
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_latch_debouncer.sv
// tb_latch_debouncer
//   Directed bench for latch_debouncer at default parameters
//   (SYNC_STAGES=2, DEBOUNCE_CYCLES=8). A per-cycle vector table drives
//   din/en and holds the expected {dout,rise,fall,busy} after each rising
//   edge; bounce and asynchronous-reset cases are written out by hand.
module tb_latch_debouncer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  latch_debouncer_if bus ();

  latch_debouncer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       din;
    logic       en;
    logic [3:0] exp;   // {dout, rise, fall, busy}
  } vec_t;

  vec_t vecs[$];

  task automatic seg(input logic din, input logic en, input int n, input logic [3:0] exp);
    for (int i = 0; i < n; i++) vecs.push_back('{din, en, exp});
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b ({dout,rise,fall,busy})", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.dout, bus.rise, bus.fall, bus.busy};
  endfunction

  // Apply inputs, advance one rising edge, land 1 time unit after it.
  task automatic tick(input logic din, input logic en);
    bus.din = din;
    bus.en  = en;
    @(posedge clk);
    #1;
  endtask

  // Strobe sanity across the whole run: never together, never back to back.
  logic prev_rise = 1'b0;
  logic prev_fall = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((bus.rise && bus.fall) || (bus.rise && prev_rise) || (bus.fall && prev_fall)) begin
        failures++;
        $display("FAIL strobe_rule got rise=%b fall=%b prev_rise=%b prev_fall=%b want isolated single strobes",
                 bus.rise, bus.fall, prev_rise, prev_fall);
      end
    end
    prev_rise = bus.rise;
    prev_fall = bus.fall;
  end

  initial begin
    // Reset release with din=1 held: rise at edge 10.
    seg(1, 1, 2, 4'b0000);
    seg(1, 1, 7, 4'b0001);
    seg(1, 1, 1, 4'b1100);
    seg(1, 1, 1, 4'b1000);
    // Falling step.
    seg(0, 1, 2, 4'b1000);
    seg(0, 1, 7, 4'b1001);
    seg(0, 1, 1, 4'b0010);
    seg(0, 1, 1, 4'b0000);
    // Clean rising step.
    seg(1, 1, 2, 4'b0000);
    seg(1, 1, 7, 4'b0001);
    seg(1, 1, 1, 4'b1100);
    seg(1, 1, 1, 4'b1000);
    // Falling step again to return to dout=0.
    seg(0, 1, 2, 4'b1000);
    seg(0, 1, 7, 4'b1001);
    seg(0, 1, 1, 4'b0010);
    seg(0, 1, 1, 4'b0000);
    // Enable abort: en drops on edge 6, then a full 8-sample recount.
    seg(1, 1, 2, 4'b0000);
    seg(1, 1, 3, 4'b0001);
    seg(1, 0, 3, 4'b0000);
    seg(1, 1, 7, 4'b0001);
    seg(1, 1, 1, 4'b1100);
    seg(1, 1, 1, 4'b1000);
    // en drop on the completing sample: abort wins, no fall.
    seg(0, 1, 2, 4'b1000);
    seg(0, 1, 7, 4'b1001);
    seg(0, 0, 2, 4'b1000);
    seg(0, 1, 7, 4'b1001);
    seg(0, 1, 1, 4'b0010);
    seg(0, 1, 1, 4'b0000);

    bus.din = 1'b1;
    bus.en  = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].din, vecs[i].en);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Bounce: 1 x5, 0 x2, then steady 1. Count restarts on edge 10 and
    // completes on edge 17.
    for (int k = 1; k <= 18; k++) begin
      tick((k == 6 || k == 7) ? 1'b0 : 1'b1, 1'b1);
      if (k <= 16) chk($sformatf("bounce_quiet%0d", k), {2'b00, bus.dout, bus.rise}, 4'b0000);
      if (k == 8)  chk("bounce_reject_busy", {3'b000, bus.busy}, 4'b0000);
      if (k == 17) chk("bounce_rise", outs(), 4'b1100);
      if (k == 18) chk("bounce_after", outs(), 4'b1000);
    end

    // Asynchronous reset while counting a fall from dout=1.
    for (int k = 1; k <= 5; k++) tick(1'b0, 1'b1);
    chk("pre_reset_count", outs(), 4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", outs(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("post_reset_idle%0d", k), outs(), 4'b0000);
    end
    for (int k = 1; k <= 11; k++) begin
      tick(1'b1, 1'b1);
      chk($sformatf("post_reset_rise%0d", k), outs(),
          (k == 11) ? 4'b1000 : (k == 10) ? 4'b1100 : (k >= 3) ? 4'b0001 : 4'b0000);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
